// File: rtl/terminal_pkg.sv
// Shared constants for the terminal text path: ASCII control codes, the printable
// range, default page geometry and the text-write state encoding.
package terminal_pkg;

   localparam logic [7:0] ASCII_BS  = 8'h08;
   localparam logic [7:0] ASCII_LF  = 8'h0A;
   localparam logic [7:0] ASCII_FF  = 8'h0C;
   localparam logic [7:0] ASCII_CR  = 8'h0D;

   localparam logic [7:0] PRINT_MIN = 8'h20;
   localparam logic [7:0] PRINT_MAX = 8'h7E;

   localparam int unsigned DEF_NUM_COLS = 80;
   localparam int unsigned DEF_NUM_ROWS = 30;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } wr_state_t;

endpackage

// File: rtl/text_write_ctrl.sv
// Text RAM write sequencer: turns received bytes into character writes, tracks the
// cursor incrementally, handles CR/LF/BS/FF and sweeps the page blank on clear.
module text_write_ctrl
   import terminal_pkg::*;
#(
   parameter int unsigned NUM_COLS   = DEF_NUM_COLS,
   parameter int unsigned NUM_ROWS   = DEF_NUM_ROWS,
   parameter int unsigned ADDR_W     = 13,
   parameter logic [7:0]  BLANK_CHAR = 8'h20,
   parameter logic [7:0]  SUBST_CHAR = 8'h2D
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [7:0]        in_char,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic [ADDR_W-1:0] cursor_addr,
   output logic              clearing
);

   localparam int unsigned CELLS = NUM_COLS * NUM_ROWS;
   localparam int unsigned COL_W = $clog2(NUM_COLS);
   localparam int unsigned ROW_W = $clog2(NUM_ROWS + 1);

   localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);
   localparam logic [ADDR_W-1:0] ROW_LEN   = ADDR_W'(NUM_COLS);
   localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(NUM_COLS - 1);
   localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(NUM_ROWS - 1);

   wr_state_t         state_q, state_d;
   logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [ADDR_W-1:0] cursor_q, cursor_d;
   logic              cr_seen_q, cr_seen_d;
   logic              in_ready_q, in_ready_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]        wr_data_q, wr_data_d;

   logic              xfer;
   logic              do_adv;
   logic              do_nl;
   logic              printable;

   assign xfer      = in_valid & in_ready_q;
   assign printable = (in_char >= PRINT_MIN) && (in_char <= PRINT_MAX);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_CLEAR;
         clr_addr_q <= '0;
         col_q      <= '0;
         row_q      <= '0;
         cursor_q   <= '0;
         cr_seen_q  <= 1'b0;
         in_ready_q <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
         col_q      <= col_d;
         row_q      <= row_d;
         cursor_q   <= cursor_d;
         cr_seen_q  <= cr_seen_d;
         in_ready_q <= in_ready_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      col_d      = col_q;
      row_d      = row_q;
      cursor_d   = cursor_q;
      cr_seen_d  = cr_seen_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      do_adv     = 1'b0;
      do_nl      = 1'b0;

      case (state_q)
         ST_CLEAR: begin
            wr_en_d   = 1'b1;
            wr_addr_d = clr_addr_q;
            wr_data_d = BLANK_CHAR;
            if (clr_addr_q == LAST_CELL) begin
               clr_addr_d = '0;
               col_d      = '0;
               row_d      = '0;
               cursor_d   = '0;
               state_d    = ST_IDLE;
            end else begin
               clr_addr_d = clr_addr_q + ADDR_W'(1);
            end
         end

         default: begin
            if (xfer) begin
               cr_seen_d = 1'b0;
               if (printable) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = cursor_q;
                  wr_data_d = in_char;
                  do_adv    = 1'b1;
               end else begin
                  case (in_char)
                     ASCII_CR: begin
                        do_nl     = 1'b1;
                        cr_seen_d = 1'b1;
                     end
                     ASCII_LF: begin
                        // LF straight after CR is the second half of a CRLF pair
                        do_nl = ~cr_seen_q;
                     end
                     ASCII_BS: begin
                        if (col_q != '0) begin
                           col_d     = col_q - COL_W'(1);
                           cursor_d  = cursor_q - ADDR_W'(1);
                           wr_en_d   = 1'b1;
                           wr_addr_d = cursor_q - ADDR_W'(1);
                           wr_data_d = BLANK_CHAR;
                        end
                     end
                     ASCII_FF: begin
                        state_d = ST_CLEAR;
                     end
                     default: begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = cursor_q;
                        wr_data_d = SUBST_CHAR;
                        do_adv    = 1'b1;
                     end
                  endcase
               end

               if (do_adv) begin
                  cursor_d = cursor_q + ADDR_W'(1);
                  if (col_q == LAST_COL) begin
                     col_d = '0;
                     row_d = row_q + ROW_W'(1);
                  end else begin
                     col_d = col_q + COL_W'(1);
                  end
               end

               if (do_nl) begin
                  cursor_d = cursor_q + (ROW_LEN - ADDR_W'(col_q));
                  col_d    = '0;
                  row_d    = row_q + ROW_W'(1);
               end

               // Leaving the last row: the current write still lands, then the page is swept
               if (((do_adv && (col_q == LAST_COL)) || do_nl) && (row_q == LAST_ROW)) begin
                  state_d = ST_CLEAR;
               end
            end
         end
      endcase

      in_ready_d = (state_d == ST_IDLE);
   end

   assign in_ready    = in_ready_q;
   assign wr_en       = wr_en_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = wr_data_q;
   assign cursor_addr = cursor_q;
   assign clearing    = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_text_write_ctrl.sv
// Bench for text_write_ctrl: directed scenarios plus a randomized byte stream,
// all checked against a row/column model of the terminal page.
module tb_text_write_ctrl;

   localparam int AW    = 13;
   localparam int COLS  = 80;
   localparam int ROWS  = 30;
   localparam int CELLS = COLS * ROWS;

   logic          clk;
   logic          reset_n;
   logic [7:0]    in_char;
   logic          in_valid;
   logic          in_ready;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;
   logic [AW-1:0] cursor_addr;
   logic          clearing;

   int checks;
   int failures;

   // model of the terminal page position
   int  m_col;
   int  m_row;
   bit  m_cr;

   text_write_ctrl dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .in_char     (in_char),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .cursor_addr (cursor_addr),
      .clearing    (clearing)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_apply(input logic [7:0] b, output bit ew, output int ea,
                              output logic [7:0] ed, output bit ec);
      bit nl;
      bit adv;
      ew = 0; ea = 0; ed = 8'h00; ec = 0; nl = 0; adv = 0;
      if (b >= 8'h20 && b <= 8'h7E) begin
         ew = 1; ea = m_row * COLS + m_col; ed = b; adv = 1;
      end else if (b == 8'h0D) begin
         nl = 1;
      end else if (b == 8'h0A) begin
         nl = !m_cr;
      end else if (b == 8'h08) begin
         if (m_col > 0) begin
            m_col = m_col - 1;
            ew = 1; ea = m_row * COLS + m_col; ed = 8'h20;
         end
      end else if (b == 8'h0C) begin
         ec = 1;
      end else begin
         ew = 1; ea = m_row * COLS + m_col; ed = 8'h2D; adv = 1;
      end
      if (adv) begin
         m_col = m_col + 1;
         if (m_col == COLS) begin
            m_col = 0; m_row = m_row + 1;
         end
      end
      if (nl) begin
         m_col = 0; m_row = m_row + 1;
      end
      if (m_row == ROWS) ec = 1;
      m_cr = (b == 8'h0D);
   endtask

   // Called at a negedge with the sweep's first write still to come.
   task automatic wait_sweep();
      int  cnt;
      int  bad_wr;
      int  bad_clr;
      bit  done;
      cnt = 0; bad_wr = 0; bad_clr = 0; done = 0;
      for (int i = 0; i < 3000 && !done; i++) begin
         @(negedge clk);
         if (wr_en === 1'b1) begin
            if (wr_addr !== AW'(cnt) || wr_data !== 8'h20) begin
               if (bad_wr == 0)
                  $display("FAIL sweep_write idx=%0d got addr=%0d data=%h want addr=%0d data=20",
                           cnt, wr_addr, wr_data, cnt);
               bad_wr++;
            end
            cnt++;
         end
         if (in_ready === 1'b1) done = 1;
         else if (clearing !== 1'b1) bad_clr++;
      end
      checks++;
      if (!done || cnt != CELLS) begin
         failures++;
         $display("FAIL sweep_length got writes=%0d ended=%0d want writes=%0d ended=1", cnt, done, CELLS);
      end
      checks++;
      if (bad_wr != 0) begin
         failures++;
         $display("FAIL sweep_content got bad_writes=%0d want 0", bad_wr);
      end
      checks++;
      if (bad_clr != 0) begin
         failures++;
         $display("FAIL sweep_clearing got low_cycles=%0d want 0", bad_clr);
      end
      checks++;
      if (cursor_addr !== AW'(0)) begin
         failures++;
         $display("FAIL sweep_cursor got %0d want 0", cursor_addr);
      end
      m_col = 0;
      m_row = 0;
   endtask

   // Called at a negedge; returns at a negedge.
   task automatic send_and_check(input logic [7:0] b, input bit auto_sweep);
      bit         ew;
      bit         ec;
      int         ea;
      logic [7:0] ed;
      int         n;
      model_apply(b, ew, ea, ed, ec);
      in_char  = b;
      in_valid = 1'b1;
      n = 0;
      while (in_ready !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) begin
         checks++;
         failures++;
         $display("FAIL handshake_timeout byte=%h got in_ready=%b want 1", b, in_ready);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (wr_en !== ew) begin
         failures++;
         $display("FAIL byte_wr_en byte=%h got %b want %b", b, wr_en, ew);
      end
      if (ew) begin
         checks++;
         if (wr_addr !== AW'(ea) || wr_data !== ed) begin
            failures++;
            $display("FAIL byte_write byte=%h got addr=%0d data=%h want addr=%0d data=%h",
                     b, wr_addr, wr_data, ea, ed);
         end
      end
      checks++;
      if (in_ready !== !ec || clearing !== ec) begin
         failures++;
         $display("FAIL byte_state byte=%h got in_ready=%b clearing=%b want in_ready=%b clearing=%b",
                  b, in_ready, clearing, !ec, ec);
      end
      if (!ec) begin
         checks++;
         if (cursor_addr !== AW'(m_row * COLS + m_col)) begin
            failures++;
            $display("FAIL byte_cursor byte=%h got %0d want %0d", b, cursor_addr, m_row * COLS + m_col);
         end
      end
      if (ec && auto_sweep) wait_sweep();
   endtask

   task automatic test_reset();
      reset_n  = 1'b0;
      in_valid = 1'b0;
      in_char  = 8'h00;
      m_col = 0; m_row = 0; m_cr = 0;
      repeat (3) @(negedge clk);
      checks++;
      if (wr_en !== 1'b0 || in_ready !== 1'b0 || clearing !== 1'b1) begin
         failures++;
         $display("FAIL reset_ctrl got wr_en=%b in_ready=%b clearing=%b want 0 0 1", wr_en, in_ready, clearing);
      end
      checks++;
      if (wr_addr !== AW'(0) || wr_data !== 8'h00 || cursor_addr !== AW'(0)) begin
         failures++;
         $display("FAIL reset_data got wr_addr=%0d wr_data=%h cursor=%0d want 0 00 0", wr_addr, wr_data, cursor_addr);
      end
      reset_n = 1'b1;
   endtask

   task automatic test_initial_sweep();
      wait_sweep();
   endtask

   task automatic test_print();
      send_and_check(8'h41, 1);
      send_and_check(8'h42, 1);
      checks++;
      if (cursor_addr !== AW'(2)) begin
         failures++;
         $display("FAIL print_cursor got %0d want 2", cursor_addr);
      end
   endtask

   task automatic test_newline();
      send_and_check(8'h63, 1);
      send_and_check(8'h64, 1);
      send_and_check(8'h65, 1);
      send_and_check(8'h0D, 1);
      send_and_check(8'h0A, 1);
      checks++;
      if (cursor_addr !== AW'(80)) begin
         failures++;
         $display("FAIL crlf_cursor got %0d want 80", cursor_addr);
      end
      send_and_check(8'h66, 1);
      send_and_check(8'h67, 1);
      send_and_check(8'h68, 1);
      send_and_check(8'h0A, 1);
      checks++;
      if (cursor_addr !== AW'(160)) begin
         failures++;
         $display("FAIL lf_cursor got %0d want 160", cursor_addr);
      end
   endtask

   task automatic test_backspace();
      send_and_check(8'h08, 1);
      send_and_check(8'h58, 1);
      send_and_check(8'h08, 1);
      checks++;
      if (cursor_addr !== AW'(160)) begin
         failures++;
         $display("FAIL bs_cursor got %0d want 160", cursor_addr);
      end
   endtask

   task automatic test_subst();
      send_and_check(8'h07, 1);
      checks++;
      if (cursor_addr !== AW'(161)) begin
         failures++;
         $display("FAIL subst_cursor got %0d want 161", cursor_addr);
      end
   endtask

   task automatic test_overflow();
      while (m_row < ROWS - 1) send_and_check(8'h0D, 1);
      while (m_col < COLS - 1) send_and_check(8'h61 + 8'(m_col % 26), 1);
      send_and_check(8'h5A, 0);
      // hold a byte valid through the whole sweep
      in_char  = 8'h51;
      in_valid = 1'b1;
      wait_sweep();
      send_and_check(8'h51, 1);
      checks++;
      if (cursor_addr !== AW'(1)) begin
         failures++;
         $display("FAIL held_byte_cursor got %0d want 1", cursor_addr);
      end
   endtask

   task automatic test_ff_reset();
      send_and_check(8'h0C, 0);
      repeat (500) @(negedge clk);
      reset_n = 1'b0;
      #1;
      checks++;
      if (wr_en !== 1'b0 || in_ready !== 1'b0 || clearing !== 1'b1 || wr_addr !== AW'(0)) begin
         failures++;
         $display("FAIL midsweep_reset got wr_en=%b in_ready=%b clearing=%b wr_addr=%0d want 0 0 1 0",
                  wr_en, in_ready, clearing, wr_addr);
      end
      @(negedge clk);
      reset_n = 1'b1;
      m_col = 0; m_row = 0; m_cr = 0;
      wait_sweep();
   endtask

   task automatic test_random();
      logic [7:0] b;
      int         r;
      int         gap;
      for (int i = 0; i < 250; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 70)       b = 8'($urandom_range(32, 126));
         else if (r < 78)  b = 8'h0D;
         else if (r < 86)  b = 8'h0A;
         else if (r < 93)  b = 8'h08;
         else if (r < 94)  b = 8'h0C;
         else if (r < 97)  b = 8'($urandom_range(128, 255));
         else              b = 8'($urandom_range(0, 7));
         send_and_check(b, 1);
         gap = int'($urandom_range(0, 2));
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            checks++;
            if (wr_en !== 1'b0) begin
               failures++;
               $display("FAIL idle_wr_en got %b want 0", wr_en);
            end
         end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_initial_sweep();
      test_print();
      test_newline();
      test_backspace();
      test_subst();
      test_overflow();
      test_ff_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
